dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter BITS, default 32, data and address width.
REQ-002 Parameter SIZE, default 128, memory depth in words; byte span is SIZE*4.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req0 / req1  input  1  access request from port 0 (pipeline MEM stage) / port 1 (loader/debug).
REQ-006 we0 / we1  input  1  1 = write, 0 = read, per port.
REQ-007 addr0 / addr1  input  BITS  byte address, per port.
REQ-008 wdata0 / wdata1  input  BITS  write data, per port.
REQ-009 gnt0 / gnt1  output  1  one-cycle pulse: the port's access is being performed this cycle.
REQ-010 rvalid0 / rvalid1  output  1  one-cycle pulse: read data valid on rdata.
REQ-011 err0 / err1  output  1  one-cycle pulse: request rejected (misaligned or out of range).
REQ-012 rdata  output  BITS  registered read data, shared by both ports.
REQ-013 mem_addr  output  BITS  byte address to data memory.
REQ-014 mem_wdata  output  BITS  write data to data memory.
REQ-015 mem_write / mem_read  output  1  data memory write / read enables.
REQ-016 mem_rdata  input  BITS  combinational read data from data memory.

Function
REQ-017 The FSM SHALL have exactly two states, IDLE and ACCESS.
REQ-018 In IDLE, on a rising edge with any reqN high, the arbiter SHALL select a winner, latch its we/addr/wdata, and enter ACCESS.
REQ-019 Arbitration SHALL be round-robin: when both ports request, the port not granted last wins; after reset, port 0 wins first.
REQ-020 The last-granted pointer SHALL update only on a real grant, not on an err rejection.
REQ-021 In ACCESS, the arbiter SHALL drive the latched command on mem_*, assert gnt of the winner for that single cycle, and return to IDLE on the next edge.
REQ-022 mem_write and mem_read SHALL be 0 in every cycle other than ACCESS.
REQ-023 For a read, mem_rdata SHALL be captured into rdata at the end of ACCESS, and rvalid of the winner SHALL pulse in the following cycle.
REQ-024 For a write, no rvalid SHALL be produced.
REQ-025 rdata SHALL hold its value until the next read completes.
REQ-026 A requester SHALL hold reqN, weN, addrN and wdataN stable until it sees gntN or errN; a request dropped before then is lost without side effects.
REQ-027 Throughput SHALL be at most one access per two cycles. Read latency, from the sampling edge to rvalid, SHALL be 2 cycles.
REQ-028 If the winner has addr[1:0] != 0 or addr >= SIZE*4, the arbiter SHALL instead pulse errN in the next cycle, stay in IDLE, and perform no memory access.
REQ-029 The losing port's request SHALL remain pending and be served on the next IDLE sampling edge.
REQ-030 mem_addr SHALL carry the full byte address; word indexing (addr>>2) is done by the memory.

Reset
REQ-031 While rst_n=0 at a rising edge: state becomes IDLE; gnt*, rvalid*, err*, mem_write and mem_read become 0; rdata, mem_addr and mem_wdata become 0; the round-robin pointer selects port 0.
REQ-032 Reset asserted during ACCESS SHALL abort the access with no rvalid. No write SHALL occur at or after that edge.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (IDLE=0, ACCESS=1) and the default BITS/SIZE constants.
REQ-034 Winner selection SHALL be a sub-module rr_arbiter2 (inputs req[1:0], last; output grant[1:0]). Everything else SHALL be flat.

Verification
REQ-035 Single read: memory word 3 = 0xDEADBEEF; req0=1, we0=0, addr0=0x0C at edge T. Required: gnt0 in cycle T+1, rvalid0 in T+2, rdata=0xDEADBEEF.
REQ-036 Write then read: port 1 writes 0x12345678 to 0x40, then reads 0x40. Required: mem_write=1 only in the write's ACCESS cycle; rvalid1 with rdata=0x12345678.
REQ-037 Contention: req0 and req1 held high continuously for 8 cycles after reset. Required: grants alternate 0,1,0,1 at 2-cycle spacing; no cycle with gnt0 and gnt1 both high.
REQ-038 Errors: addr0=0x0E, then addr0=0x200 (SIZE=128). Required: err0 pulse one cycle after each sampling edge, mem_write=mem_read=0 throughout, round-robin pointer unchanged.
REQ-039 Reset mid-access: rst_n=0 during the ACCESS cycle of a write. Required: all outputs 0 on the next cycle and no rvalid. Then req1 alone: gnt1 issued, pointer restarted from port 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default constants for the data-memory arbiter.
package dmem_arbiter_pkg;

    // Arbiter FSM encoding: one idle/sampling state and one access state.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Default data/address width and memory depth in words.
    localparam int DEF_BITS = 32;
    localparam int DEF_SIZE = 128;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner selection. 'last' is the index of the port
// granted most recently; on contention the other port wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot winner from the request pair and the last-granted pointer.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: samples requests in IDLE, performs one
// memory access in ACCESS, returns read data one cycle later.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int SIZE = DEF_SIZE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0,
    input  logic            req1,
    input  logic            we0,
    input  logic            we1,
    input  logic [BITS-1:0] addr0,
    input  logic [BITS-1:0] addr1,
    input  logic [BITS-1:0] wdata0,
    input  logic [BITS-1:0] wdata1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            rvalid0,
    output logic            rvalid1,
    output logic            err0,
    output logic            err1,
    output logic [BITS-1:0] rdata,
    output logic [BITS-1:0] mem_addr,
    output logic [BITS-1:0] mem_wdata,
    output logic            mem_write,
    output logic            mem_read,
    input  logic [BITS-1:0] mem_rdata
);

    // First byte address past the end of the memory.
    localparam logic [BITS-1:0] SPAN = BITS'(SIZE * 4);

    state_t            state_r;
    state_t            state_s;
    logic              last_r;
    logic              win_r;
    logic [1:0]        grant_s;
    logic              win_s;
    logic              any_req_s;
    logic              sel_we_s;
    logic [BITS-1:0]   sel_addr_s;
    logic [BITS-1:0]   sel_wdata_s;
    logic              sel_ok_s;
    logic              gnt0_r;
    logic              gnt1_r;
    logic              rvalid0_r;
    logic              rvalid1_r;
    logic              err0_r;
    logic              err1_r;
    logic [BITS-1:0]   rdata_r;
    logic [BITS-1:0]   mem_addr_r;
    logic [BITS-1:0]   mem_wdata_r;
    logic              mem_write_r;
    logic              mem_read_r;

    rr_arbiter2 u_rr (
        .req   ({req1, req0}),
        .last  (last_r),
        .grant (grant_s)
    );

    assign any_req_s = req0 | req1;
    assign win_s     = grant_s[1];

    // Route the winning port's command and check alignment and range.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        if (grant_s[1]) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
        sel_ok_s = (sel_addr_s[1:0] == 2'b00) && (sel_addr_s < SPAN);
    end

    // Next-state logic: rejected requests keep the FSM in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s && sel_ok_s) begin
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register, command latch, pulse outputs and read capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            last_r      <= 1'b1;
            win_r       <= 1'b0;
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
            rvalid0_r   <= 1'b0;
            rvalid1_r   <= 1'b0;
            err0_r      <= 1'b0;
            err1_r      <= 1'b0;
            rdata_r     <= '0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
            rvalid0_r   <= 1'b0;
            rvalid1_r   <= 1'b0;
            err0_r      <= 1'b0;
            err1_r      <= 1'b0;
            mem_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        if (sel_ok_s) begin
                            gnt0_r      <= grant_s[0];
                            gnt1_r      <= grant_s[1];
                            mem_addr_r  <= sel_addr_s;
                            mem_wdata_r <= sel_wdata_s;
                            mem_write_r <= sel_we_s;
                            mem_read_r  <= ~sel_we_s;
                            win_r       <= win_s;
                            last_r      <= win_s;
                        end else begin
                            err0_r <= grant_s[0];
                            err1_r <= grant_s[1];
                        end
                    end
                end
                ACCESS: begin
                    if (mem_read_r) begin
                        rdata_r   <= mem_rdata;
                        rvalid0_r <= ~win_r;
                        rvalid1_r <= win_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt0      = gnt0_r;
    assign gnt1      = gnt1_r;
    assign rvalid0   = rvalid0_r;
    assign rvalid1   = rvalid1_r;
    assign err0      = err0_r;
    assign err1      = err1_r;
    assign rdata     = rdata_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    // Enables are masked by reset so an access aborted by reset never
    // commits a write on the reset edge.
    assign mem_write = mem_write_r & rst_n;
    assign mem_read  = mem_read_r & rst_n;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, mem_init;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;
    logic [31:0] mem [0:127];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.BITS(32), .SIZE(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .err0(err0), .err1(err1), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    // Behavioural memory: preload word i = 0x1000_0000+i, word 3 = DEADBEEF.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem[3] <= 32'hDEAD_BEEF;
        end else if (mem_write) begin
            mem[mem_addr[8:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[8:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] flags();
        return {24'd0, gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_write, mem_read};
    endfunction

    // flag bit positions: gnt0=80 gnt1=40 rvalid0=20 rvalid1=10 err0=08 err1=04 wr=02 rd=01
    logic [31:0] cont_exp [1:8];
    logic [31:0] cont_rd  [1:8];

    initial begin
        cont_exp[1] = 32'h81; cont_exp[2] = 32'h20; cont_exp[3] = 32'h41; cont_exp[4] = 32'h10;
        cont_exp[5] = 32'h81; cont_exp[6] = 32'h20; cont_exp[7] = 32'h41; cont_exp[8] = 32'h10;
        cont_rd[1]  = 32'h0;  cont_rd[2]  = 32'h1000_0004; cont_rd[3] = 32'h1000_0004;
        cont_rd[4]  = 32'h1000_0008; cont_rd[5] = 32'h1000_0008; cont_rd[6] = 32'h1000_0004;
        cont_rd[7]  = 32'h1000_0004; cont_rd[8] = 32'h1000_0008;

        rst_n = 1'b0; mem_init = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        tick(); tick();
        chk("rst_flags", flags(), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_maddr", mem_addr, 32'h0);
        chk("rst_mwdata", mem_wdata, 32'h0);
        rst_n = 1'b1; mem_init = 1'b0;

        // Contention: both read continuously, port 0 first after reset.
        req0 = 1'b1; addr0 = 32'h10; req1 = 1'b1; addr1 = 32'h20;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("cont_flags_%0d", k), flags(), cont_exp[k]);
            chk($sformatf("cont_rdata_%0d", k), rdata, cont_rd[k]);
        end
        req0 = 1'b0; req1 = 1'b0;

        // Single read of word 3.
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0C;
        tick();
        chk("rd_gnt", flags(), 32'h81);
        chk("rd_maddr", mem_addr, 32'h0C);
        req0 = 1'b0;
        tick();
        chk("rd_rvalid", flags(), 32'h20);
        chk("rd_rdata", rdata, 32'hDEAD_BEEF);

        // Port 1 writes 0x40 then reads it back.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'h1234_5678;
        tick();
        chk("wr_gnt", flags(), 32'h42);
        chk("wr_maddr", mem_addr, 32'h40);
        chk("wr_mwdata", mem_wdata, 32'h1234_5678);
        req1 = 1'b0;
        tick();
        chk("wr_after", flags(), 32'h0);
        chk("wr_rdata_hold", rdata, 32'hDEAD_BEEF);
        req1 = 1'b1; we1 = 1'b0;
        tick();
        chk("rb_gnt", flags(), 32'h41);
        req1 = 1'b0;
        tick();
        chk("rb_rvalid", flags(), 32'h10);
        chk("rb_rdata", rdata, 32'h1234_5678);

        // Misaligned then out-of-range on port 0.
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0E;
        tick();
        chk("err_misal", flags(), 32'h08);
        req0 = 1'b0;
        tick();
        chk("err_misal_after", flags(), 32'h0);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h200; wdata0 = 32'h5555_AAAA;
        tick();
        chk("err_range", flags(), 32'h08);
        req0 = 1'b0; we0 = 1'b0;
        tick();
        chk("err_range_after", flags(), 32'h0);

        // Pointer still says port 1 was last: port 0 wins, port 1 waits.
        req0 = 1'b1; addr0 = 32'h0C; req1 = 1'b1; addr1 = 32'h40;
        tick();
        chk("ptr_gnt0", flags(), 32'h81);
        req0 = 1'b0;
        tick();
        chk("ptr_rvalid0", flags(), 32'h20);
        tick();
        chk("ptr_gnt1", flags(), 32'h41);
        req1 = 1'b0;
        tick();
        chk("ptr_rdata1", rdata, 32'h1234_5678);

        // Last in-range word.
        req0 = 1'b1; addr0 = 32'h1FC;
        tick();
        chk("top_gnt", flags(), 32'h81);
        req0 = 1'b0;
        tick();
        chk("top_rdata", rdata, 32'h1000_007F);

        // Reset during the ACCESS cycle of a write.
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h08; wdata0 = 32'hCAFE_F00D;
        tick();
        chk("rstw_gnt", flags(), 32'h82);
        rst_n = 1'b0; req0 = 1'b0; we0 = 1'b0;
        tick();
        chk("rstw_flags", flags(), 32'h0);
        chk("rstw_rdata", rdata, 32'h0);
        chk("rstw_maddr", mem_addr, 32'h0);
        chk("rstw_mwdata", mem_wdata, 32'h0);
        rst_n = 1'b1;

        // Pointer restarted at port 0; aborted write left word 2 intact.
        req0 = 1'b1; addr0 = 32'h08; req1 = 1'b1; addr1 = 32'h0C;
        tick();
        chk("rst_ptr_gnt0", flags(), 32'h81);
        req0 = 1'b0;
        tick();
        chk("rst_nowrite", rdata, 32'h1000_0002);
        tick();
        chk("rst_gnt1", flags(), 32'h41);
        req1 = 1'b0;
        tick();
        chk("rst_rvalid1", flags(), 32'h10);
        chk("rst_rdata1", rdata, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
